// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment serial chain: CTRL bit positions,
// shift-engine state encoding and the digit-word count helper.
package seven_segment_pkg;

    localparam int CTRL_AUTO    = 0;
    localparam int CTRL_GO      = 1;
    localparam int CTRL_BUSY    = 8;
    localparam int CTRL_PENDING = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } seg_state_t;

    // Number of 32-bit words needed to hold num_digits bytes.
    function automatic int num_words(input int num_digits);
        return (num_digits + 3) / 4;
    endfunction

endpackage

// File: rtl/seven_segment_shift_engine.sv
// Serialises a snapshot of all digit bytes onto a 74HC595-style chain:
// data changes while the shift clock is low, a latch pulse closes the frame.
module seven_segment_shift_engine
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NUM_DIGITS*8-1:0]   digits_flat,
    output seg_state_t                state,
    output logic                      pending,
    output logic                      ser_data,
    output logic                      ser_clk,
    output logic                      ser_latch
);

    localparam int NB = NUM_DIGITS * 8;
    localparam int BW = $clog2(NB);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [NB-1:0] shadow;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          div_done;

    assign div_done = (div_cnt == DW'(CLK_DIV - 1));

    // Every serial output is its own flop, loaded on the phase transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            pending   <= 1'b0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            div_cnt <= div_done ? '0 : div_cnt + 1'b1;
            if (start && state != ST_IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    div_cnt <= '0;
                    if (start) begin
                        state    <= ST_LOW;
                        shadow   <= digits_flat;
                        bit_cnt  <= BW'(NB - 1);
                        ser_data <= digits_flat[NB-1];
                    end
                end
                ST_LOW: begin
                    if (div_done) begin
                        state   <= ST_HIGH;
                        ser_clk <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (div_done) begin
                        ser_clk <= 1'b0;
                        if (bit_cnt == '0) begin
                            state     <= ST_LATCH;
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                        end else begin
                            state    <= ST_LOW;
                            shadow   <= {shadow[NB-2:0], 1'b0};
                            bit_cnt  <= bit_cnt - 1'b1;
                            ser_data <= shadow[NB-2];
                        end
                    end
                end
                ST_LATCH: begin
                    if (div_done) begin
                        ser_latch <= 1'b0;
                        // A request arriving on the last latch cycle is served by this same fresh snapshot.
                        if (pending || start) begin
                            pending  <= 1'b0;
                            state    <= ST_LOW;
                            shadow   <= digits_flat;
                            bit_cnt  <= BW'(NB - 1);
                            ser_data <= digits_flat[NB-1];
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_serial_chain_avalon.sv
// Avalon-MM register file for NUM_DIGITS segment bytes plus CTRL; start
// requests are handed to the shift engine that drives the display chain.
module seven_segment_serial_chain_avalon
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4,
    parameter int ADDR_W     = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_chipselect,
    input  logic              avs_s0_write,
    input  logic              avs_s0_read,
    input  logic [3:0]        avs_s0_byteenable,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    output logic              ser_data_export,
    output logic              ser_clk_export,
    output logic              ser_latch_export
);

    localparam int W = num_words(NUM_DIGITS);

    logic [NUM_DIGITS*8-1:0] digits_q;
    logic [NUM_DIGITS*8-1:0] digits_d;
    logic                    auto_q;
    logic                    wr_en;
    logic                    rd_en;
    logic                    ctrl_wr;
    logic                    digit_hit;
    logic                    start_req;
    logic                    busy;
    logic                    eng_pending;
    logic [31:0]             read_word;
    seg_state_t              eng_state;

    assign wr_en   = avs_s0_chipselect && avs_s0_write;
    assign rd_en   = avs_s0_chipselect && avs_s0_read;
    assign ctrl_wr = wr_en && (avs_s0_address == ADDR_W'(W)) && avs_s0_byteenable[0];
    assign busy    = (eng_state != ST_IDLE);

    // digits_d is the post-write value, so a snapshot taken on the write edge sees the new byte.
    always_comb begin
        digits_d  = digits_q;
        digit_hit = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (wr_en && avs_s0_address == ADDR_W'(k / 4) && avs_s0_byteenable[k % 4]) begin
                digits_d[k*8 +: 8] = avs_s0_writedata[(k % 4)*8 +: 8];
                digit_hit          = 1'b1;
            end
        end
    end

    assign start_req = (ctrl_wr && avs_s0_writedata[CTRL_GO]) || (auto_q && digit_hit);

    always_comb begin
        read_word = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (avs_s0_address == ADDR_W'(k / 4)) begin
                read_word[(k % 4)*8 +: 8] = digits_q[k*8 +: 8];
            end
        end
        if (avs_s0_address == ADDR_W'(W)) begin
            read_word[CTRL_AUTO]    = auto_q;
            read_word[CTRL_BUSY]    = busy;
            read_word[CTRL_PENDING] = eng_pending;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digits_q        <= '0;
            auto_q          <= 1'b0;
            avs_s0_readdata <= '0;
        end else begin
            digits_q        <= digits_d;
            avs_s0_readdata <= rd_en ? read_word : '0;
            if (ctrl_wr) begin
                auto_q <= avs_s0_writedata[CTRL_AUTO];
            end
        end
    end

    seven_segment_shift_engine #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV)
    ) u_engine (
        .clk         (clock),
        .rst_n       (resetn),
        .start       (start_req),
        .digits_flat (digits_d),
        .state       (eng_state),
        .pending     (eng_pending),
        .ser_data    (ser_data_export),
        .ser_clk     (ser_clk_export),
        .ser_latch   (ser_latch_export)
    );

endmodule

// File: tb/tb_seven_segment_serial_chain_avalon.sv
// Directed bench: an 8-digit and a 3-digit instance on a shared Avalon bus,
// each with a pin monitor that reassembles the shifted frame.
module tb_seven_segment_serial_chain_avalon;

    logic        clock;
    logic        resetn;
    logic [2:0]  address;
    logic        cs8, cs3;
    logic        write, read;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] rd8, rd3;
    logic        sd8, sc8, sl8;
    logic        sd3, sc3, sl3;

    int checks = 0;
    int errors = 0;

    int           busy_cyc [2];
    int           rx_cnt   [2];
    int           latch_cyc[2];
    int           latch_cnt[2];
    logic [127:0] rx_vec   [2];
    logic         pclk     [2];
    logic         plat     [2];
    logic [63:0]  exp_q[$];

    seven_segment_serial_chain_avalon #(.NUM_DIGITS(8), .CLK_DIV(2), .ADDR_W(3)) u8 (
        .clock (clock), .resetn (resetn),
        .avs_s0_address (address), .avs_s0_chipselect (cs8),
        .avs_s0_write (write), .avs_s0_read (read),
        .avs_s0_byteenable (byteenable), .avs_s0_writedata (writedata),
        .avs_s0_readdata (rd8),
        .ser_data_export (sd8), .ser_clk_export (sc8), .ser_latch_export (sl8)
    );

    seven_segment_serial_chain_avalon #(.NUM_DIGITS(3), .CLK_DIV(2), .ADDR_W(3)) u3 (
        .clock (clock), .resetn (resetn),
        .avs_s0_address (address), .avs_s0_chipselect (cs3),
        .avs_s0_write (write), .avs_s0_read (read),
        .avs_s0_byteenable (byteenable), .avs_s0_writedata (writedata),
        .avs_s0_readdata (rd3),
        .ser_data_export (sd3), .ser_clk_export (sc3), .ser_latch_export (sl3)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pin monitors, sampled on the falling edge
    always @(negedge clock) begin
        if (resetn) begin
            if (u8.busy) busy_cyc[0]++;
            if (sc8 && !pclk[0]) begin
                rx_vec[0] = {rx_vec[0][126:0], sd8};
                rx_cnt[0]++;
            end
            if (sl8) latch_cyc[0]++;
            if (sl8 && !plat[0]) latch_cnt[0]++;
        end
        pclk[0] = resetn ? sc8 : 1'b0;
        plat[0] = resetn ? sl8 : 1'b0;
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (u3.busy) busy_cyc[1]++;
            if (sc3 && !pclk[1]) begin
                rx_vec[1] = {rx_vec[1][126:0], sd3};
                rx_cnt[1]++;
            end
            if (sl3) latch_cyc[1]++;
            if (sl3 && !plat[1]) latch_cnt[1]++;
        end
        pclk[1] = resetn ? sc3 : 1'b0;
        plat[1] = resetn ? sl3 : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            busy_cyc[i]  = 0;
            rx_cnt[i]    = 0;
            latch_cyc[i] = 0;
            latch_cnt[i] = 0;
            rx_vec[i]    = '0;
        end
    endtask

    // Driver tasks; sel 0 = 8-digit, 1 = 3-digit, other = no chipselect
    task automatic avs_write(input int sel, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        cs8 = (sel == 0); cs3 = (sel == 1);
        @(negedge clock);
        write = 1'b0; cs8 = 1'b0; cs3 = 1'b0;
    endtask

    task automatic avs_read(input int sel, input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        address = a; read = 1'b1;
        cs8 = (sel == 0); cs3 = (sel == 1);
        @(negedge clock);
        read = 1'b0; cs8 = 1'b0; cs3 = 1'b0;
        d = (sel == 0) ? rd8 : rd3;
    endtask

    task automatic wait_idle(input int sel, input string tag);
        logic b;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            b = (sel == 0) ? u8.busy : u3.busy;
            if (!b) break;
        end
        b = (sel == 0) ? u8.busy : u3.busy;
        check(tag, 64'(b), 64'd0);
    endtask

    logic [31:0] rdata;
    logic [63:0] exp_frame;

    initial begin
        resetn = 1'b0; address = '0; cs8 = 1'b0; cs3 = 1'b0;
        write = 1'b0; read = 1'b0; byteenable = '0; writedata = '0;
        for (int i = 0; i < 2; i++) begin
            pclk[i] = 1'b0;
            plat[i] = 1'b0;
        end
        clear_mon();

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_readdata", 64'(rd8), 64'd0);
        check("rst_pins", 64'({sd8, sc8, sl8}), 64'd0);
        check("rst_busy", 64'(u8.busy), 64'd0);
        resetn = 1'b1;
        avs_read(0, 3'd0, rdata);
        check("rst_word0", 64'(rdata), 64'd0);
        avs_read(0, 3'd2, rdata);
        check("rst_ctrl", 64'(rdata), 64'd0);

        // One-shot frame
        avs_write(0, 3'd0, 32'h44332211, 4'hF);
        avs_write(0, 3'd1, 32'h88776655, 4'hF);
        clear_mon();
        avs_write(0, 3'd2, 32'h2, 4'hF);
        check("go_busy_next", 64'(u8.busy), 64'd1);
        wait_idle(0, "frame1_done");
        check("frame1_busy_cyc", 64'(busy_cyc[0]), 64'd258);
        check("frame1_bits", 64'(rx_cnt[0]), 64'd64);
        check("frame1_first_byte", 64'(rx_vec[0][63:56]), 64'h88);
        check("frame1_data", rx_vec[0][63:0], 64'h8877665544332211);
        check("frame1_latch_width", 64'(latch_cyc[0]), 64'd2);
        check("frame1_latch_pulses", 64'(latch_cnt[0]), 64'd1);

        // Byte-lane write, no frame while AUTO=0
        avs_write(0, 3'd0, 32'hAABBCCDD, 4'h2);
        check("lane_no_frame", 64'(u8.busy), 64'd0);
        avs_read(0, 3'd0, rdata);
        check("lane_readback", 64'(rdata), 64'h4433CC11);
        @(negedge clock);
        check("readdata_cleared", 64'(rd8), 64'd0);

        // AUTO mode with collapsed pending requests
        avs_write(0, 3'd2, 32'h1, 4'hF);
        check("auto_no_start", 64'(u8.busy), 64'd0);
        clear_mon();
        exp_q.push_back(64'h887766994433CC11);
        exp_q.push_back(64'hA07766994433CC01);
        avs_write(0, 3'd1, 32'h00000099, 4'h1);
        check("auto_busy_next", 64'(u8.busy), 64'd1);
        repeat (20) @(negedge clock);
        avs_write(0, 3'd0, 32'h00000001, 4'h1);
        avs_write(0, 3'd1, 32'hA0000000, 4'h8);
        avs_read(0, 3'd2, rdata);
        check("auto_ctrl_pending", 64'(rdata), 64'h301);
        wait_idle(0, "auto_done");
        check("auto_busy_cyc", 64'(busy_cyc[0]), 64'd516);
        check("auto_bits", 64'(rx_cnt[0]), 64'd128);
        check("auto_latch_pulses", 64'(latch_cnt[0]), 64'd2);
        exp_frame = exp_q.pop_front();
        check("auto_frame_a", rx_vec[0][127:64], exp_frame);
        exp_frame = exp_q.pop_front();
        check("auto_frame_b", rx_vec[0][63:0], exp_frame);
        avs_read(0, 3'd2, rdata);
        check("auto_ctrl_idle", 64'(rdata), 64'h1);
        avs_write(0, 3'd2, 32'h0, 4'hF);

        // Reset mid-frame
        clear_mon();
        avs_write(0, 3'd2, 32'h2, 4'hF);
        for (int i = 0; i < 200; i++) begin
            if (rx_cnt[0] >= 10) break;
            @(negedge clock);
        end
        check("midrst_reach_bit10", 64'(rx_cnt[0]), 64'd10);
        #2 resetn = 1'b0;
        #1;
        check("midrst_pins", 64'({sd8, sc8, sl8}), 64'd0);
        check("midrst_busy", 64'(u8.busy), 64'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        check("midrst_no_latch", 64'(latch_cnt[0]), 64'd0);
        avs_read(0, 3'd0, rdata);
        check("midrst_word0", 64'(rdata), 64'd0);
        avs_read(0, 3'd1, rdata);
        check("midrst_word1", 64'(rdata), 64'd0);
        avs_read(0, 3'd2, rdata);
        check("midrst_ctrl", 64'(rdata), 64'd0);

        // Ignored writes
        avs_write(2, 3'd0, 32'h12345678, 4'hF);
        avs_write(2, 3'd2, 32'h3, 4'hF);
        check("nocs_no_frame", 64'(u8.busy), 64'd0);
        avs_read(0, 3'd0, rdata);
        check("nocs_word0", 64'(rdata), 64'd0);
        avs_write(0, 3'd3, 32'hFFFFFFFF, 4'hF);
        check("badaddr_no_frame", 64'(u8.busy), 64'd0);
        avs_read(0, 3'd3, rdata);
        check("badaddr_read", 64'(rdata), 64'd0);
        avs_read(0, 3'd2, rdata);
        check("badaddr_ctrl", 64'(rdata), 64'd0);
        avs_read(0, 3'd0, rdata);
        check("badaddr_word0", 64'(rdata), 64'd0);

        // Three-digit instance
        avs_write(1, 3'd0, 32'hFFFFFFFF, 4'hF);
        avs_read(1, 3'd0, rdata);
        check("n3_readback", 64'(rdata), 64'h00FFFFFF);
        clear_mon();
        avs_write(1, 3'd1, 32'h2, 4'hF);
        check("n3_busy_next", 64'(u3.busy), 64'd1);
        wait_idle(1, "n3_done");
        check("n3_busy_cyc", 64'(busy_cyc[1]), 64'd98);
        check("n3_bits", 64'(rx_cnt[1]), 64'd24);
        check("n3_data", 64'(rx_vec[1][23:0]), 64'hFFFFFF);
        check("n3_latch_pulses", 64'(latch_cnt[1]), 64'd1);
        check("n3_other_idle", 64'(busy_cyc[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_serial_chain_avalon.md
Name: seven_segment_serial_chain_avalon

Overview:
Avalon-MM slave holding NUM_DIGITS byte-wide segment patterns. It serialises them onto a chain of cascaded 8-bit shift-register display drivers (74HC595-style: data, shift clock, latch). It supports one-shot and auto-refresh modes, a programmable serial clock divider, busy status and register readback. It sits between the Qsys/Platform Designer interconnect and the board display header, in place of the single-byte parallel display interface.

Parameters:
NUM_DIGITS, 8, number of cascaded 8-bit driver stages/digits (1..16)
CLK_DIV, 4, clock cycles per serial clock half-period (>=1)
ADDR_W, 3, width of avs_s0_address (must cover ceil(NUM_DIGITS/4)+1 words)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
avs_s0_address  in  ADDR_W  word address
avs_s0_chipselect  in  1  slave select
avs_s0_write  in  1  write strobe
avs_s0_read  in  1  read strobe
avs_s0_byteenable  in  4  byte lanes for write
avs_s0_writedata  in  32  write data
avs_s0_readdata  out  32  read data, read latency 1
ser_data_export  out  1  serial data to chain
ser_clk_export  out  1  shift clock, data changes while low
ser_latch_export  out  1  storage latch pulse, active high

Behaviour:
- Reset: clock and reset are fixed as one clock, `clock`; reset `resetn` is asynchronous, active-low. While resetn is low, all digit bytes, the control register, pending, FSM and all outputs are 0, and readdata is 0.
- Address map, with W = ceil(NUM_DIGITS/4):
  - Words 0..W-1 hold the digits; digit k is at word k/4, byte lane k%4.
  - Word W is CTRL. On write: bit0 = AUTO, bit1 = GO (self-clearing). On read: bit0 = AUTO, bit1 = 0, bit8 = BUSY, bit9 = PENDING.
  - Other addresses read 0; writes to them are ignored.
- A write takes effect only when chipselect and write are both high. Only enabled byte lanes update. Lanes with index >= NUM_DIGITS are ignored on write and read as 0.
- Read: when chipselect and read are high, readdata is registered and valid on the next clock edge.
- Start request: any of the following raises a start request:
  - a CTRL write with GO=1;
  - with AUTO=1, any digit write that has at least one effective byte lane.
- Start handling:
  - If IDLE: the FSM leaves IDLE on the next edge.
  - If not IDLE: PENDING is set (requests collapse, at most one pending).
- FSM states: IDLE, LOW, HIGH, LATCH.
  - IDLE->LOW: all digits are snapshotted into a shadow register of NUM_DIGITS*8 bits, and bit_cnt is set to NUM_DIGITS*8-1. A digit write in the same cycle as the snapshot is captured by this snapshot.
  - LOW (CLK_DIV cycles): ser_clk=0 and ser_data = current bit.
  - HIGH (CLK_DIV cycles): ser_clk=1. On exit, if bit_cnt=0 go to LATCH; otherwise shift and decrement, then go to LOW.
  - LATCH (CLK_DIV cycles): ser_clk=0, ser_latch=1. On exit, if PENDING: clear it and go to LOW with a fresh snapshot (no IDLE cycle). Otherwise go to IDLE.
- Bit order: digit NUM_DIGITS-1 first, MSB first within each byte, so that digit 0 ends in the first chain stage.
- BUSY = (state != IDLE). A frame lasts exactly (16*NUM_DIGITS+1)*CLK_DIV cycles.
- Outputs are registered, glitch-free, and driven directly from state/shadow flops. ser_data is 0 in IDLE and LATCH.
- Clearing AUTO mid-frame does not abort the frame. GO written while busy sets PENDING.
- Reset asserted mid-frame aborts immediately: outputs go to 0 asynchronously and no latch pulse is generated.

Decomposition:
- Shared package (seven_segment_pkg): CTRL bit indices (AUTO=0, GO=1, BUSY=8, PENDING=9), FSM state encoding, and the function computing W from NUM_DIGITS.
- Sub-module seven_segment_shift_engine: contains the FSM, divider counter, bit counter and shadow shift register. Interface: start, digits_flat in, busy/pending out, the three serial outputs.
- Top level: Avalon register file, readback and start-request logic.

Test Plan:
- NUM_DIGITS=8, CLK_DIV=2. Write 0x44332211 to word 0 and 0x88776655 to word 1 (be=0xF), then CTRL=0x2. Required: BUSY rises the next cycle; the first 8 bits sampled on ser_clk rising edges are 1,0,0,0,1,0,0,0 (0x88); total 64 bits; a latch pulse 2 cycles wide; BUSY high exactly 258 cycles.
- Write 0xAABBCCDD to word 0 with be=0x2 -> word 0 reads back 0x4433CC11 with readdata valid one cycle after read; no frame starts while AUTO=0.
- AUTO=1: a digit write while IDLE starts a frame the next cycle. Two digit writes during the frame -> PENDING reads 1 and exactly one extra frame follows, back-to-back with no IDLE cycle; the second frame carries the updated digits.
- Pull resetn low during bit 10 -> ser_clk, ser_data and ser_latch are 0 within the same cycle with no latch pulse; after release, words read 0 and CTRL reads 0.
- Write with chipselect=0, and write to address W+1 -> no register change and no frame; address W+1 reads 0.
- NUM_DIGITS=3: writing 0xFFFFFFFF to word 0 reads back 0x00FFFFFF; a frame shifts exactly 24 bits and BUSY is high for (49*CLK_DIV) cycles.
